// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM states, data width, line levels.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_xmtr_if.sv
// Byte-enqueue handshake between a producer (master) and the transmitter FIFO (slave).
interface uart_xmtr_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_xmtr_fifo.sv
// Byte FIFO for the transmitter; push is ignored when full, pop is ignored when empty.
module uart_xmtr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is defined by count_q alone.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_xmtr.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop framing FSM.
// state     | meaning
// IDLE      | line high, waiting for a queued byte and uart_txen
// START     | start bit (low) for one bit period
// DATA      | 8 data bits, LSB first
// PARITY    | even-parity bit (only when PARITY_EN = 1)
// STOP      | STOP_BITS stop bits (high); may chain straight into START
module uart_xmtr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 3,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_txen,
  uart_xmtr_if.slave                    tx_if,
  output logic                          uart_sout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 sout_q, sout_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 start_ok, tc, do_load;

  // Assertion is immediate; release reaches the core after two clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign rst_int    = rst_sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end

  uart_xmtr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clock   (clock),
    .reset   (rst_int),
    .push    (tx_if.tx_valid),
    .wr_data (tx_if.tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign busy           = (state_q != ST_IDLE);
  assign uart_sout      = sout_q;
  assign start_ok       = !fifo_empty && uart_txen;
  assign tc             = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    sout_d     = sout_q;
    fifo_pop   = 1'b0;
    do_load    = 1'b0;

    if (!tc) cnt_d = cnt_q - CW'(1);

    case (state_q)
      ST_IDLE: if (start_ok) do_load = 1'b1;
      ST_START: if (tc) begin
        state_d = ST_DATA;
        sout_d  = shift_q[0];
        shift_d = shift_q >> 1;
        idx_d   = '0;
        cnt_d   = BIT_LAST;
      end
      ST_DATA: if (tc) begin
        cnt_d = BIT_LAST;
        idx_d = idx_q + 3'd1;
        if (idx_q == IDX_LAST) begin
          stop_idx_d = 1'b0;
          if (PARITY_EN != 0) begin
            state_d = ST_PARITY;
            sout_d  = par_q;
          end else begin
            state_d = ST_STOP;
            sout_d  = LINE_STOP;
          end
        end else begin
          sout_d  = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_PARITY: if (tc) begin
        state_d    = ST_STOP;
        sout_d     = LINE_STOP;
        cnt_d      = BIT_LAST;
        stop_idx_d = 1'b0;
      end
      ST_STOP: if (tc) begin
        if (stop_idx_q != STOP_LAST) begin
          stop_idx_d = stop_idx_q + 1'b1;
          cnt_d      = BIT_LAST;
        end else if (start_ok) begin
          do_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          sout_d  = LINE_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = LINE_IDLE;
      end
    endcase

    // Shared by IDLE->START and the back-to-back STOP->START path.
    if (do_load) begin
      state_d  = ST_START;
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      par_d    = ^fifo_rdata;
      sout_d   = LINE_START;
      cnt_d    = BIT_LAST;
    end
  end

  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      sout_q     <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      sout_q     <= sout_d;
    end
  end

endmodule
